// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit lookahead slice per stage,
// carry registered between slices, valid/ready handshake with bubble compression.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    generate
        if (WIDTH % STAGES != 0) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be divisible by STAGES");
        end
        if (SW % GROUP != 0) begin : g_bad_group
            $error("pipelined_cla_adder: WIDTH/STAGES must be divisible by GROUP");
        end
    endgenerate

    // Returns {carry into slice MSB, carry out, sum}; groups resolve via group G/P.
    function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic          ci);
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          gg;
        logic          gp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < SW / GROUP; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                c[j*GROUP+i+1] = g[j*GROUP+i] | (p[j*GROUP+i] & c[j*GROUP+i]);
                gg             = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp             = gp & p[j*GROUP+i];
            end
            c[(j+1)*GROUP] = gg | (gp & c[j*GROUP]);
        end
        return {c[SW-1], c[SW], p ^ c[SW-1:0]};
    endfunction

    logic [WIDTH-1:0] op_a [STAGES];
    logic [WIDTH-1:0] op_b [STAGES];
    logic [WIDTH-1:0] ps   [STAGES+1];
    logic [STAGES:0]  cy;
    logic [STAGES:0]  v;
    logic [STAGES-1:0] ld;
    logic             msb_c;

    assign op_a[0] = a;
    assign op_b[0] = sub ? ~b : b;
    assign cy[0]   = sub | cin;
    assign ps[0]   = '0;
    assign v[0]    = in_valid;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [SW+1:0]    r;
            logic [WIDTH-1:0] s_nx;
            logic [WIDTH-1:0] s_q;
            logic             v_q;
            logic             c_q;

            // Stage k may load unless it and every stage after it is full and stalled.
            assign ld[k] = out_ready | ~(&v[STAGES:k+1]);
            assign r     = slice_add(op_a[k][k*SW +: SW], op_b[k][k*SW +: SW], cy[k]);

            always_comb begin
                s_nx               = ps[k];
                s_nx[k*SW +: SW]   = r[SW-1:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (ld[k]) begin
                    v_q <= v[k];
                    if (v[k]) begin
                        s_q <= s_nx;
                        c_q <= r[SW];
                    end
                end
            end

            assign v[k+1]  = v_q;
            assign ps[k+1] = s_q;
            assign cy[k+1] = c_q;

            if (k < STAGES - 1) begin : g_skew
                logic [WIDTH-1:0] a_q;
                logic [WIDTH-1:0] b_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (ld[k] && v[k]) begin
                        a_q <= op_a[k];
                        b_q <= op_b[k];
                    end
                end
                assign op_a[k+1] = a_q;
                assign op_b[k+1] = b_q;
            end else begin : g_last
                logic cm_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cm_q <= 1'b0;
                    end else if (ld[k] && v[k]) begin
                        cm_q <= r[SW+1];
                    end
                end
                assign msb_c = cm_q;
            end
        end
    endgenerate

    assign in_ready  = ld[0];
    assign out_valid = v[STAGES];
    assign s         = ps[STAGES];
    assign cout      = cy[STAGES];
    assign ovf       = cy[STAGES] ^ msb_c;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed vectors, throughput, backpressure,
// mid-flight reset and a random handshake soak against a behavioural model.
module tb_pipelined_cla_adder;

    localparam int W = 32;
    localparam int S = 2;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W), .STAGES(S), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // {ovf, cout, s}
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic [W:0]   sum;
        logic         o;
        be  = ms ? ~mb : mb;
        sum = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, (ms | mc)};
        o   = (ma[W-1] == be[W-1]) && (sum[W-1] != ma[W-1]);
        return {o, sum[W], sum[W-1:0]};
    endfunction

    logic [W+1:0] exp_q [$];
    logic [W+1:0] mon_e;
    logic [W-1:0] s_hold;
    bit           mon_en = 0;
    bit           pv = 0;
    bit           pr = 0;
    int           n_out = 0;
    int           n_in = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_s", s, s_hold);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_out", 1'b1, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", {ovf, cout, s}, mon_e);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                n_in++;
            end
            pv     = out_valid;
            pr     = out_ready;
            s_hold = s;
        end
    end

    task automatic dir(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_rdy"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, S);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    task automatic drive_rand(input bit valid);
        a        = $urandom();
        b        = $urandom();
        cin      = 1'($urandom_range(0, 1));
        sub      = 1'($urandom_range(0, 1));
        in_valid = valid;
    endtask

    initial begin
        int  first_out;
        int  acc;
        bit  stale;
        int  guard;

        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_s", s, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        dir("carry_chain", 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir("pos_ovf",     32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        dir("sub_neg",     32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir("sub_ovf",     32'h8000_0000, 32'h1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        dir("add_cin",     32'h3,         32'h4,         1'b1, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        dir("sub_cin_ign", 32'hA,         32'h3,         1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        dir("neg_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        dir("sub_zero",    32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        dir("slice_carry", 32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

        // back-to-back stream
        mon_en = 1; pv = 0; n_out = 0; n_in = 0; out_ready = 1'b1; first_out = -1;
        for (int cyc = 0; cyc < 10 + S + 2; cyc++) begin
            drive_rand(cyc < 10);
            @(negedge clk);
            if (out_valid && first_out < 0) first_out = cyc;
            @(posedge clk); #1;
        end
        chk("tp_first_out", first_out, S);
        chk("tp_count", n_out, 10);
        chk("tp_queue_empty", exp_q.size(), 0);

        // stall with the pipe being fed
        n_out = 0; acc = 0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            drive_rand(1'b1);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", acc, S);
        chk("bp_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk); #1;
        chk("bp_drained", n_out, S);
        chk("bp_queue_empty", exp_q.size(), 0);

        // reset while full
        out_ready = 1'b0;
        for (int cyc = 0; cyc < S; cyc++) begin
            drive_rand(1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full", out_valid, 1'b1);
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_s", s, '0);
        chk("mid_rst_cout", cout, 1'b0);
        chk("mid_rst_ovf", ovf, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 1'b0;
        for (int cyc = 0; cyc < 2 * S + 2; cyc++) begin
            @(negedge clk);
            stale = stale | out_valid;
        end
        chk("mid_no_stale", stale, 1'b0);
        chk("mid_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // random handshake soak
        mon_en = 1; pv = 0; n_out = 0; n_in = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive_rand(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        chk("soak_queue_empty", exp_q.size(), 0);
        chk("soak_count", n_out, n_in);
        mon_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
